// File: rtl/expr_seq_if.sv
// Host-side bus of expr_seq.
//   s_*   : character stream into the string FIFO (valid/ready, s_last ends a string)
//   res_* : per-string result handshake (ok verdict, overflow flag, length)
// master = host, slave = expr_seq.
interface expr_seq_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic       res_valid;
  logic       res_ready;
  logic       res_ok;
  logic       res_ovf;
  logic [7:0] res_len;

  modport master (
    output s_valid, s_data, s_last, res_ready,
    input  s_ready, res_valid, res_ok, res_ovf, res_len
  );

  modport slave (
    input  s_valid, s_data, s_last, res_ready,
    output s_ready, res_valid, res_ok, res_ovf, res_len
  );
endinterface

// File: rtl/expr_seq.sv
// expr_seq: sequencer for a single-character expression recognizer.
// Buffers whole strings from the host in a DEPTH-entry FIFO, then per string
// clears the recognizer, feeds one char per cycle with no gaps, samples its
// verdict and returns {ok, ovf, len} over a result handshake. Strings longer
// than DEPTH are drained without touching the recognizer and reported as ovf.
// Ports:
//   clk, clr_n      clock / async active-low reset
//   bus (slave)     s_valid/s_ready/s_data/s_last stream, res_* result handshake
//   chk_clr, chk_in registered drive to recognizer clr / in
//   chk_out         recognizer verdict
//   busy            controller not idle
//   ok_cnt,fail_cnt only with EXPR_SEQ_STATS_EN: wrapping result counters
module expr_seq #(
  parameter int          DEPTH     = 8,
  parameter int          AW        = 3,
  parameter logic [7:0]  IDLE_CHAR = 8'd0
) (
  input  logic        clk,
  input  logic        clr_n,
  expr_seq_if.slave   bus,
  output logic        chk_clr,
  output logic [7:0]  chk_in,
  input  logic        chk_out,
  output logic        busy
`ifdef EXPR_SEQ_STATS_EN
  ,
  output logic [15:0] ok_cnt,
  output logic [15:0] fail_cnt
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CLEAR, ST_FEED, ST_WAIT, ST_DROP, ST_REPORT
  } state_e;

  state_e state_q, state_d;

  // ---------------- FIFO ----------------
  logic [8:0]  mem_q [DEPTH];
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] nstr_q, nstr_d;
  logic        full, empty, push, pop;
  logic [8:0]  rd;
  logic        rd_last;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  // s_ready depends only on registered state: a pop this cycle cannot reopen it.
  assign bus.s_ready = !full;
  assign push    = bus.s_valid && !full;
  assign rd      = mem_q[rptr_q[AW-1:0]];
  assign rd_last = rd[8];

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= {bus.s_last, bus.s_data};
  end

  always_comb begin
    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop  ? rptr_q + 1'b1 : rptr_q;
    nstr_d = nstr_q;
    case ({push && bus.s_last, pop && rd_last})
      2'b10:   nstr_d = nstr_q + 1'b1;
      2'b01:   nstr_d = nstr_q - 1'b1;
      default: nstr_d = nstr_q;
    endcase
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (nstr_q != '0) state_d = ST_CLEAR;
        else if (full)    state_d = ST_DROP;
      end
      ST_CLEAR:  state_d = ST_FEED;
      ST_FEED:   if (pop && rd_last) state_d = ST_WAIT;
      ST_WAIT:   state_d = ST_REPORT;
      ST_DROP:   if (pop && rd_last) state_d = ST_REPORT;
      ST_REPORT: if (bus.res_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // ---------------- outputs / datapath ----------------
  logic       chk_clr_q, chk_clr_d;
  logic [7:0] chk_in_q, chk_in_d;
  logic [7:0] len_q, len_d;
  logic       res_ok_q, res_ok_d, res_ovf_q, res_ovf_d;

  always_comb begin
    pop       = 1'b0;
    // chk_* registered off the next state so the recognizer sees clean edges.
    chk_clr_d = (state_d == ST_CLEAR);
    chk_in_d  = IDLE_CHAR;
    len_d     = len_q;
    res_ok_d  = res_ok_q;
    res_ovf_d = res_ovf_q;
    case (state_q)
      ST_IDLE:  len_d = '0;
      ST_CLEAR: len_d = '0;
      ST_FEED: begin
        pop      = !empty;
        chk_in_d = pop ? rd[7:0] : IDLE_CHAR;
        if (pop && len_q != 8'hFF) len_d = len_q + 8'd1;
      end
      ST_WAIT: begin
        res_ok_d  = chk_out;
        res_ovf_d = 1'b0;
      end
      ST_DROP: begin
        // the tail of an oversized string may still be arriving
        pop = !empty;
        if (pop && len_q != 8'hFF) len_d = len_q + 8'd1;
        if (pop && rd_last) begin
          res_ok_d  = 1'b0;
          res_ovf_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      nstr_q    <= '0;
      chk_clr_q <= 1'b1;
      chk_in_q  <= IDLE_CHAR;
      len_q     <= '0;
      res_ok_q  <= 1'b0;
      res_ovf_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      nstr_q    <= nstr_d;
      chk_clr_q <= chk_clr_d;
      chk_in_q  <= chk_in_d;
      len_q     <= len_d;
      res_ok_q  <= res_ok_d;
      res_ovf_q <= res_ovf_d;
    end
  end

  assign chk_clr       = chk_clr_q;
  assign chk_in        = chk_in_q;
  assign bus.res_valid = (state_q == ST_REPORT);
  assign bus.res_ok    = res_ok_q;
  assign bus.res_ovf   = res_ovf_q;
  assign bus.res_len   = len_q;
  assign busy          = (state_q != ST_IDLE);

`ifdef EXPR_SEQ_STATS_EN
  logic [15:0] ok_cnt_q, ok_cnt_d, fail_cnt_q, fail_cnt_d;
  logic        hs;

  assign hs = bus.res_valid && bus.res_ready;

  always_comb begin
    ok_cnt_d   = ok_cnt_q;
    fail_cnt_d = fail_cnt_q;
    if (hs) begin
      if (res_ok_q) ok_cnt_d   = ok_cnt_q + 16'd1;
      else          fail_cnt_d = fail_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ok_cnt_q   <= '0;
      fail_cnt_q <= '0;
    end else begin
      ok_cnt_q   <= ok_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign ok_cnt   = ok_cnt_q;
  assign fail_cnt = fail_cnt_q;
`endif

endmodule

// File: tb/tb_expr_seq.sv
// Bench for expr_seq: directed strings, scoreboard of hand-computed results
// checked by an independent monitor, plus a small behavioural recognizer
// (digit (op digit)*, NUL ignored, Mealy verdict).
module tb_expr_seq;
  logic       clk = 1'b0;
  logic       clr_n;
  logic       chk_clr;
  logic [7:0] chk_in;
  logic       chk_out;
  logic       busy;
`ifdef EXPR_SEQ_STATS_EN
  logic [15:0] ok_cnt, fail_cnt;
`endif

  expr_seq_if ifc();

  expr_seq dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .bus     (ifc),
    .chk_clr (chk_clr),
    .chk_in  (chk_in),
    .chk_out (chk_out),
    .busy    (busy)
`ifdef EXPR_SEQ_STATS_EN
    ,
    .ok_cnt  (ok_cnt),
    .fail_cnt(fail_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- recognizer model ----------------
  logic [1:0] rs;  // 0 start, 1 after digit (accept), 2 after op, 3 error

  function automatic logic [1:0] rnext(input logic [1:0] s, input logic [7:0] c);
    logic dig, op;
    dig = (c >= 8'd48) && (c <= 8'd57);
    op  = (c == 8'd42) || (c == 8'd43);
    if (c == 8'd0) return s;
    case (s)
      2'd0:    return dig ? 2'd1 : 2'd3;
      2'd1:    return op  ? 2'd2 : 2'd3;
      2'd2:    return dig ? 2'd1 : 2'd3;
      default: return 2'd3;
    endcase
  endfunction

  always @(posedge clk) begin
    if (chk_clr) rs <= 2'd0;
    else         rs <= rnext(rs, chk_in);
  end
  assign chk_out = (rnext(rs, chk_in) == 2'd1);

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;

  typedef struct {
    bit ok;
    bit ovf;
    int len;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // result monitor: pops the scoreboard on every accepted result
  always @(negedge clk) begin
    if (clr_n === 1'b1 && ifc.res_valid === 1'b1 && ifc.res_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got len %0d expected no result", ifc.res_len);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("res_ok",  ifc.res_ok,  e.ok);
        chk("res_ovf", ifc.res_ovf, e.ovf);
        chk("res_len", ifc.res_len, e.len);
      end
    end
  end

  // recognizer-side logger: clr pulses and fed characters with timestamps
  int       cyc = 0;
  int       clr_pulses = 0;
  logic     clr_prev = 1'b0;
  int       log_v[$];
  int       log_t[$];

  always @(negedge clk) begin
    cyc++;
    if (chk_clr && !clr_prev) clr_pulses++;
    clr_prev = chk_clr;
    if (chk_in != 8'd0) begin
      log_v.push_back(int'(chk_in));
      log_t.push_back(cyc);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_ch(input logic [7:0] d, input logic l);
    int t;
    t = 0;
    @(negedge clk);
    ifc.s_valid = 1'b1;
    ifc.s_data  = d;
    ifc.s_last  = l;
    while (ifc.s_ready !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) chk("push_timeout", 1, 0);
    @(posedge clk);
    #1;
    ifc.s_valid = 1'b0;
    ifc.s_last  = 1'b0;
  endtask

  task automatic push_str(input string s, input bit exp_en, input bit ok, input bit ovf, input int len);
    if (exp_en) exp_q.push_back('{ok: ok, ovf: ovf, len: len});
    for (int i = 0; i < s.len(); i++) push_ch(s[i], (i == s.len() - 1));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy === 1'b1) && t < 600) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", (t >= 600) ? 1 : 0, 0);
    @(negedge clk);
  endtask

  task automatic check_log(input string s);
    chk("log_size", log_v.size(), s.len());
    if (log_v.size() == s.len()) begin
      for (int i = 0; i < s.len(); i++) begin
        chk("chk_in_char", log_v[i], int'(s[i]));
        if (i > 0) chk("chk_in_gapless", log_t[i] - log_t[i-1], 1);
      end
    end
  endtask

  task automatic clear_log();
    log_v.delete();
    log_t.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c0, t;
    bit stable;

    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, t;
    bit stable;
    string s10;

    clr_n         = 1'b0;
    ifc.s_valid   = 1'b0;
    ifc.s_data    = 8'd0;
    ifc.s_last    = 1'b0;
    ifc.res_ready = 1'b1;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_chk_clr",   chk_clr,       1);
    chk("rst_chk_in",    chk_in,        0);
    chk("rst_res_valid", ifc.res_valid, 0);
    chk("rst_res_ok",    ifc.res_ok,    0);
    chk("rst_res_ovf",   ifc.res_ovf,   0);
    chk("rst_res_len",   ifc.res_len,   0);
    chk("rst_busy",      busy,          0);
    chk("rst_s_ready",   ifc.s_ready,   1);
    clr_n = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_release", chk_clr, 0);

    // valid expression
    clear_log();
    c0 = clr_pulses;
    push_str("1*2+3", 1, 1, 0, 5);
    drain();
    chk("t1_clr_pulses", clr_pulses - c0, 1);
    check_log("1*2+3");

    // incomplete expression
    clear_log();
    push_str("1*2+", 1, 0, 0, 4);
    drain();
    check_log("1*2+");
    chk("t2_chk_in_idle", chk_in, 0);

    // result held while host stalls; second string waits
    @(posedge clk); #1;
    ifc.res_ready = 1'b0;
    push_str("1", 1, 1, 0, 1);
    push_str("2+3", 1, 1, 0, 3);
    t = 0;
    while (ifc.res_valid !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("t3_valid_timeout", (t >= 100) ? 1 : 0, 0);
    c0 = clr_pulses;
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (ifc.res_valid !== 1'b1 || ifc.res_ok !== 1'b1 || ifc.res_ovf !== 1'b0 ||
          ifc.res_len !== 8'd1 || busy !== 1'b1) stable = 1'b0;
    end
    chk("t3_held_stable", stable, 1);
    chk("t3_no_second_clr", clr_pulses - c0, 0);
    @(posedge clk); #1;
    ifc.res_ready = 1'b1;
    drain();
    chk("t3_second_clr", clr_pulses - c0, 1);

    // oversized string: dropped, recognizer untouched
    clear_log();
    c0 = clr_pulses;
    s10 = "1+1+1+1+1+";
    exp_q.push_back('{ok: 1'b0, ovf: 1'b1, len: 10});
    for (int i = 0; i < 8; i++) push_ch(s10[i], 1'b0);
    chk("t4_full_s_ready", ifc.s_ready, 0);
    push_ch(s10[8], 1'b0);
    push_ch(s10[9], 1'b1);
    drain();
    chk("t4_no_clr", clr_pulses - c0, 0);
    chk("t4_no_feed", log_v.size(), 0);

    // reset during FEED
    push_str("1*2+3", 0, 0, 0, 0);
    t = 0;
    while (chk_in == 8'd0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("t5_feed_timeout", (t >= 50) ? 1 : 0, 0);
    @(posedge clk); #2;
    clr_n = 1'b0;
    #1;
    chk("t5_chk_clr",   chk_clr,       1);
    chk("t5_chk_in",    chk_in,        0);
    chk("t5_res_valid", ifc.res_valid, 0);
    chk("t5_busy",      busy,          0);
    chk("t5_s_ready",   ifc.s_ready,   1);
    @(posedge clk); #2;
    clr_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("t5_no_result", ifc.res_valid, 0);
    clear_log();
    push_str("7", 1, 1, 0, 1);
    drain();
    check_log("7");

`ifdef EXPR_SEQ_STATS_EN
    clr_n = 1'b0;
    @(posedge clk); #2;
    clr_n = 1'b1;
    push_str("1", 1, 1, 0, 1);
    push_str("1+", 1, 0, 0, 2);
    push_str("2*3", 1, 1, 0, 3);
    push_str("+", 1, 0, 0, 1);
    push_str("4+5", 1, 1, 0, 3);
    drain();
    chk("stats_ok",   ok_cnt,   3);
    chk("stats_fail", fail_cnt, 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
